// File: rtl/instr_reg_scanner.sv
// instr_reg_scanner: read-side companion of the instruction register.
// Walks read_pointer over a window of entries, samples each instruction word,
// recomputes the expected result from opc/op_a/op_b and streams one check
// record per entry over a valid/ready handshake.
// Build option: define SCAN_MISMATCH_ONLY_EN to emit only mismatching records.

package instr_reg_scanner_pkg;
    localparam logic [3:0] OPC_ZERO  = 4'd0;
    localparam logic [3:0] OPC_PASSA = 4'd1;
    localparam logic [3:0] OPC_PASSB = 4'd2;
    localparam logic [3:0] OPC_ADD   = 4'd3;
    localparam logic [3:0] OPC_SUB   = 4'd4;
    localparam logic [3:0] OPC_MULT  = 4'd5;
    localparam logic [3:0] OPC_DIV   = 4'd6;
    localparam logic [3:0] OPC_MOD   = 4'd7;

    typedef struct packed {
        logic [3:0]         opc;
        logic signed [31:0] op_a;
        logic signed [31:0] op_b;
        logic signed [63:0] res;
    } instruction_t;
endpackage

module instr_reg_scanner
    import instr_reg_scanner_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int ERR_W = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [AW-1:0]    start_ptr,
    input  logic [AW:0]      num_entries,
    output logic [AW-1:0]    read_pointer,
    input  instruction_t     instruction_word,
    output logic             rec_valid,
    input  logic             rec_ready,
    output logic [AW-1:0]    rec_addr,
    output logic [3:0]       rec_opc,
    output logic [63:0]      rec_expected,
    output logic             rec_mismatch,
    output logic             busy,
    output logic             done,
    output logic [ERR_W-1:0] err_count
);

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_SAMPLE, S_EMIT, S_DONE} state_e;

    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    state_e             state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        remaining_q, remaining_d;
    logic [AW-1:0]      rec_addr_q, rec_addr_d;
    logic [3:0]         rec_opc_q, rec_opc_d;
    logic [63:0]        rec_exp_q, rec_exp_d;
    logic               rec_mm_q, rec_mm_d;
    logic [ERR_W-1:0]   err_q, err_d;

    logic [AW:0]        num_clamped;
    logic [AW-1:0]      ptr_inc;
    logic               last_entry;
    logic signed [63:0] a64, b64, exp_c;
    logic               ab_zero, legal_c, mm_c;

    // Oversized requests scan the whole register once; pointer wraps at DEPTH.
    assign num_clamped = (num_entries > DEPTH_C) ? DEPTH_C : num_entries;
    assign ptr_inc     = (ptr_q == AW'(DEPTH - 1)) ? '0 : ptr_q + AW'(1);
    assign last_entry  = (remaining_q == (AW+1)'(1));

    // Recompute the expected result of the word currently on the read port.
    always_comb begin
        a64     = {{32{instruction_word.op_a[31]}}, instruction_word.op_a};
        b64     = {{32{instruction_word.op_b[31]}}, instruction_word.op_b};
        ab_zero = (a64 == '0) || (b64 == '0);
        legal_c = 1'b1;
        exp_c   = '0;
        case (instruction_word.opc)
            OPC_ZERO:  exp_c = '0;
            OPC_PASSA: exp_c = a64;
            OPC_PASSB: exp_c = b64;
            OPC_ADD:   exp_c = a64 + b64;
            OPC_SUB:   exp_c = a64 - b64;
            OPC_MULT:  if (!ab_zero) exp_c = a64 * b64;
            OPC_DIV:   if (!ab_zero) exp_c = a64 / b64;
            OPC_MOD:   if (!ab_zero) exp_c = a64 % b64;
            default:   legal_c = 1'b0;
        endcase
        // An illegal opcode is checked against an all-zero ZERO entry.
        if (legal_c) begin
            mm_c = (instruction_word.res != exp_c);
        end else begin
            mm_c = (instruction_word.opc != OPC_ZERO) || (instruction_word.op_a != '0) ||
                   (instruction_word.op_b != '0) || (instruction_word.res != '0);
        end
    end

    // Scan sequencing: next state and next values of every register.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        rd_ptr_d    = rd_ptr_q;
        remaining_d = remaining_q;
        rec_addr_d  = rec_addr_q;
        rec_opc_d   = rec_opc_q;
        rec_exp_d   = rec_exp_q;
        rec_mm_d    = rec_mm_q;
        err_d       = err_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    ptr_d       = start_ptr;
                    remaining_d = num_clamped;
                    err_d       = '0;
                    state_d     = (num_clamped == '0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR: begin
                rd_ptr_d = ptr_q;
                state_d  = S_SAMPLE;
            end
            S_SAMPLE: begin
                rec_addr_d = ptr_q;
                rec_opc_d  = instruction_word.opc;
                rec_exp_d  = exp_c;
                rec_mm_d   = mm_c;
`ifdef SCAN_MISMATCH_ONLY_EN
                if (mm_c) begin
                    state_d = S_EMIT;
                end else begin
                    remaining_d = remaining_q - (AW+1)'(1);
                    ptr_d       = ptr_inc;
                    state_d     = last_entry ? S_DONE : S_ADDR;
                end
`else
                state_d = S_EMIT;
`endif
            end
            S_EMIT: begin
                if (rec_ready) begin
                    if (rec_mm_q && (err_q != '1)) err_d = err_q + ERR_W'(1);
                    remaining_d = remaining_q - (AW+1)'(1);
                    ptr_d       = ptr_inc;
                    state_d     = last_entry ? S_DONE : S_ADDR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any scan in progress.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            rd_ptr_q    <= '0;
            remaining_q <= '0;
            rec_addr_q  <= '0;
            rec_opc_q   <= '0;
            rec_exp_q   <= '0;
            rec_mm_q    <= 1'b0;
            err_q       <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            remaining_q <= remaining_d;
            rec_addr_q  <= rec_addr_d;
            rec_opc_q   <= rec_opc_d;
            rec_exp_q   <= rec_exp_d;
            rec_mm_q    <= rec_mm_d;
            err_q       <= err_d;
        end
    end

    assign read_pointer = rd_ptr_q;
    assign rec_valid    = (state_q == S_EMIT);
    assign rec_addr     = rec_addr_q;
    assign rec_opc      = rec_opc_q;
    assign rec_expected = rec_exp_q;
    assign rec_mismatch = rec_mm_q;
    assign busy         = (state_q == S_ADDR) || (state_q == S_SAMPLE) || (state_q == S_EMIT);
    assign done         = (state_q == S_DONE);
    assign err_count    = err_q;

endmodule
